// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues one word-aligned fetch at a time, holds the
// returned instruction for decode, and handles branch/jump redirects. A redirect to a
// misaligned target parks the block in a sticky error state until reset.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_tgt_q, redir_tgt_d;
   logic        misalign_q, misalign_d;
   // Misaligned redirect seen mid-request: keep requesting until the ack, then go to ERR.
   logic        err_pend_q, err_pend_d;

   logic        redir_bad;

   assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

   // Next-state logic: fetch sequencing, redirect handling and error capture.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
      misalign_d   = misalign_q;
      err_pend_d   = err_pend_q;

      unique case (state_q)
         StIdle: begin
            if (redir_bad) begin
               misalign_d = 1'b1;
               state_d    = StErr;
            end else begin
               // An early redirect replaces the reset vector as the first fetch.
               if (redirect_valid) begin
                  pc_d = redirect_pc;
               end
               state_d = StReq;
            end
         end

         StReq: begin
            if (err_pend_q) begin
               // Redirects are ignored; the outstanding ack is consumed and dropped.
               if (imem_ack) begin
                  err_pend_d = 1'b0;
                  state_d    = StErr;
               end
            end else if (redir_bad) begin
               misalign_d   = 1'b1;
               redir_pend_d = 1'b0;
               if (imem_ack) begin
                  state_d = StErr;
               end else begin
                  err_pend_d = 1'b1;
               end
            end else if (redirect_valid) begin
               if (imem_ack) begin
                  // Data for the old path is dropped; refetch from the target.
                  pc_d         = redirect_pc;
                  redir_pend_d = 1'b0;
               end else begin
                  // Address must stay stable until ack, so only latch the target.
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = redirect_pc;
               end
            end else if (imem_ack) begin
               if (redir_pend_q) begin
                  pc_d         = redir_tgt_q;
                  redir_pend_d = 1'b0;
               end else begin
                  inst_d    = imem_rdata;
                  inst_pc_d = pc_q;
                  pc_d      = pc_q + 32'd4;
                  state_d   = StHold;
               end
            end
         end

         StHold: begin
            if (redir_bad) begin
               misalign_d = 1'b1;
               state_d    = StErr;
            end else if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = StReq;
            end else if (inst_ready) begin
               state_d = StReq;
            end
         end

         StErr: begin
            state_d = StErr;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         pc_q         <= RESET_VECTOR;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= 32'h0;
         misalign_q   <= 1'b0;
         err_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
         misalign_q   <= misalign_d;
         err_pend_q   <= err_pend_d;
      end
   end

   assign imem_req     = (state_q == StReq);
   assign imem_addr    = pc_q;
   assign inst_valid   = (state_q == StHold);
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign misalign_err = misalign_q;

   // Protocol properties: stable request address, stable held instruction, sticky error.
   a_addr_stable: assert property (@(posedge clk)
      (!rst && state_q == StReq && !imem_ack) |=> (rst || pc_q == $past(pc_q)));

   a_hold_stable: assert property (@(posedge clk)
      (!rst && state_q == StHold && !inst_ready && !redirect_valid) |=>
         (rst || (state_q == StHold && inst_q == $past(inst_q) &&
                  inst_pc_q == $past(inst_pc_q))));

   a_err_sticky: assert property (@(posedge clk)
      (!rst && misalign_q) |=> (rst || misalign_q));

endmodule
